// File: rtl/traffic_light_monitor.sv
// ---------------------------------------------------------------------------
// traffic_light_monitor
//
// Passive checker for the traffic-light controller outputs. The light
// pattern is decoded into a phase. The monitor then checks phase-to-phase
// transitions, phase durations and the pedestrian-request rule. The first
// violation is latched as a sticky fault code. Completed cycles (MG
// entries) and pedestrian phases (PG entries) are counted.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high
//   main_lights  in   [2:0] {red,yellow,green} main road
//   sec_lights   in   [2:0] {red,yellow,green} secondary road
//   pea_lights   in   [1:0] {red,green} pedestrian
//   sol_light    in   pedestrian-request-pending LED
//   phase        out  [2:0] decoded phase (0 ALLRED,1 MG,2 MY,3 SG,4 SY,5 PG,7 ILLEGAL)
//   fault        out  sticky: any violation since reset
//   fault_code   out  [3:0] first violation (0 none,1 ILLEGAL_COMBO,2 BAD_TRANSITION,
//                     3 SHORT_PHASE,4 LONG_PHASE,5 UNREQ_PED)
//   fault_pulse  out  one-clk strobe when fault_code is latched
//   cycle_cnt    out  [7:0] MG entries since reset, saturating
//   ped_cnt      out  [7:0] PG entries since reset, saturating
// ---------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int FPGAFREQ      = 50_000_000,
  parameter int T_GREENMAIN   = 18,
  parameter int T_YELLOWMAIN  = 4,
  parameter int T_GREENSEC    = 10,
  parameter int T_YELLOWSEC   = 3,
  parameter int T_GREENPEATON = 5,
  parameter int T_REDPEATON   = 2,
  parameter int TOL_CLK       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] main_lights,
  input  logic [2:0] sec_lights,
  input  logic [1:0] pea_lights,
  input  logic       sol_light,
  output logic [2:0] phase,
  output logic       fault,
  output logic [3:0] fault_code,
  output logic       fault_pulse,
  output logic [7:0] cycle_cnt,
  output logic [7:0] ped_cnt
);

  typedef enum logic [2:0] {
    PH_ALLRED  = 3'd0,
    PH_MG      = 3'd1,
    PH_MY      = 3'd2,
    PH_SG      = 3'd3,
    PH_SY      = 3'd4,
    PH_PG      = 3'd5,
    PH_ILLEGAL = 3'd7
  } phase_t;

  localparam int               CNT_W   = $clog2(T_GREENMAIN * FPGAFREQ + TOL_CLK + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Nominal duration of each phase in clocks; ALLRED is the pedestrian
  // clearance interval.
  function automatic int expected_clks(input phase_t ph);
    case (ph)
      PH_ALLRED: return T_REDPEATON   * FPGAFREQ;
      PH_MG:     return T_GREENMAIN   * FPGAFREQ;
      PH_MY:     return T_YELLOWMAIN  * FPGAFREQ;
      PH_SG:     return T_GREENSEC    * FPGAFREQ;
      PH_SY:     return T_YELLOWSEC   * FPGAFREQ;
      PH_PG:     return T_GREENPEATON * FPGAFREQ;
      default:   return 0;
    endcase
  endfunction

  function automatic logic is_legal(input phase_t from_ph, input phase_t to_ph);
    case (from_ph)
      PH_ALLRED: return to_ph == PH_MG;
      PH_MG:     return to_ph == PH_MY;
      PH_MY:     return to_ph == PH_SG;
      PH_SG:     return to_ph == PH_SY;
      PH_SY:     return (to_ph == PH_MG) || (to_ph == PH_PG);
      PH_PG:     return to_ph == PH_ALLRED;
      default:   return 1'b0;
    endcase
  endfunction

  // Stage 1: the decoded inputs. Stage 2: r_cur_phase, which the checks use.
  phase_t           r_phase;
  logic             r_sol;
  phase_t           r_cur_phase;
  logic [CNT_W-1:0] r_elapsed;
  logic             r_first;
  logic             r_req_seen;
  logic             r_fault;
  logic [3:0]       r_fault_code;
  logic             r_fault_pulse;
  logic [7:0]       r_cycle_cnt;
  logic [7:0]       r_ped_cnt;

  phase_t           w_decoded;
  logic             w_change;
  logic [CNT_W-1:0] w_elapsed_next;
  int               w_exp_cur;
  logic             w_illegal;
  logic             w_bad_trans;
  logic             w_short;
  logic             w_long;
  logic             w_unreq;
  logic [3:0]       w_code;

  always_comb begin
    w_decoded = PH_ILLEGAL;
    case ({main_lights, sec_lights, pea_lights})
      8'b100_100_10: w_decoded = PH_ALLRED;
      8'b001_100_10: w_decoded = PH_MG;
      8'b010_100_10: w_decoded = PH_MY;
      8'b100_001_10: w_decoded = PH_SG;
      8'b100_010_10: w_decoded = PH_SY;
      8'b100_100_01: w_decoded = PH_PG;
      default:       w_decoded = PH_ILLEGAL;
    endcase
  end

  // A change is seen when stage 1 differs from stage 2. At that moment
  // r_elapsed still holds the full length of the phase being left.
  always_comb begin
    w_change  = (r_phase != r_cur_phase);
    w_exp_cur = expected_clks(r_cur_phase);

    w_elapsed_next = r_elapsed;
    if (w_change) begin
      w_elapsed_next = CNT_W'(1);
    end else if (r_elapsed != CNT_MAX) begin
      w_elapsed_next = r_elapsed + CNT_W'(1);
    end

    w_illegal   = w_change && (r_phase == PH_ILLEGAL);
    w_bad_trans = w_change && !is_legal(r_cur_phase, r_phase);
    // The phase held across reset has unknown age, so it is never timed.
    w_short     = w_change && !r_first && (r_cur_phase != PH_ILLEGAL) &&
                  (int'(r_elapsed) < (w_exp_cur - TOL_CLK));
    w_long      = !w_change && !r_first && (r_cur_phase != PH_ILLEGAL) &&
                  (int'(w_elapsed_next) == (w_exp_cur + TOL_CLK + 1));
    w_unreq     = w_change && (r_cur_phase == PH_SY) && (r_phase == PH_PG) &&
                  !r_req_seen;

    // Priority encoder: the lowest code wins when violations coincide.
    w_code = 4'd0;
    if (w_illegal) begin
      w_code = 4'd1;
    end else if (w_bad_trans) begin
      w_code = 4'd2;
    end else if (w_short) begin
      w_code = 4'd3;
    end else if (w_long) begin
      w_code = 4'd4;
    end else if (w_unreq) begin
      w_code = 4'd5;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase       <= PH_ALLRED;
      r_sol         <= 1'b0;
      r_cur_phase   <= PH_ALLRED;
      r_elapsed     <= '0;
      r_first       <= 1'b1;
      r_req_seen    <= 1'b0;
      r_fault       <= 1'b0;
      r_fault_code  <= 4'd0;
      r_fault_pulse <= 1'b0;
      r_cycle_cnt   <= 8'd0;
      r_ped_cnt     <= 8'd0;
    end else begin
      r_phase     <= w_decoded;
      r_sol       <= sol_light;
      r_cur_phase <= r_phase;
      r_elapsed   <= w_elapsed_next;

      if (w_change) begin
        r_first <= 1'b0;
      end

      // Entering PG serves the pending request; a request seen on that
      // same clock does not carry over to the next pedestrian phase.
      if (w_change && (r_phase == PH_PG)) begin
        r_req_seen <= 1'b0;
      end else if (r_sol) begin
        r_req_seen <= 1'b1;
      end

      r_fault_pulse <= 1'b0;
      if (!r_fault && (w_code != 4'd0)) begin
        r_fault       <= 1'b1;
        r_fault_code  <= w_code;
        r_fault_pulse <= 1'b1;
      end

      if (w_change && (r_phase == PH_MG) && (r_cycle_cnt != 8'hFF)) begin
        r_cycle_cnt <= r_cycle_cnt + 8'd1;
      end
      if (w_change && (r_phase == PH_PG) && (r_ped_cnt != 8'hFF)) begin
        r_ped_cnt <= r_ped_cnt + 8'd1;
      end
    end
  end

  assign phase       = r_phase;
  assign fault       = r_fault;
  assign fault_code  = r_fault_code;
  assign fault_pulse = r_fault_pulse;
  assign cycle_cnt   = r_cycle_cnt;
  assign ped_cnt     = r_ped_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Drives light patterns into traffic_light_monitor. The bench runs directed
// scenarios with hand-computed expectations. It then checks counter
// saturation, followed by randomized phase sequences. A behavioural model
// works at the level of input clocks: the run length per phase, a request
// flag and a pending-violation slot. The model predicts every output. It
// is compared with the DUT on each falling edge.
// ---------------------------------------------------------------------------
module tb_traffic_light_monitor;

  localparam int FREQ = 8;
  localparam int TOL  = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] main_l = 3'b100;
  logic [2:0] sec_l = 3'b100;
  logic [1:0] pea_l = 2'b10;
  logic       sol = 1'b0;
  logic [2:0] phase;
  logic       fault;
  logic [3:0] fault_code;
  logic       fault_pulse;
  logic [7:0] cycle_cnt;
  logic [7:0] ped_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit tb_done = 1'b0;

  // Patterns indexed by phase number: ALLRED, MG, MY, SG, SY, PG.
  logic [7:0] pat_tab [6] = '{8'b100_100_10, 8'b001_100_10, 8'b010_100_10,
                              8'b100_001_10, 8'b100_010_10, 8'b100_100_01};
  // Nominal clocks per phase for the bench parameters (index 7 = illegal).
  int exp_clks [8] = '{2*FREQ, 18*FREQ, 3*FREQ, 6*FREQ, 2*FREQ, 4*FREQ, 0, 0};
  int leg_from [7] = '{0, 1, 2, 3, 4, 4, 5};
  int leg_to   [7] = '{1, 2, 3, 4, 1, 5, 0};

  traffic_light_monitor #(
    .FPGAFREQ(FREQ), .T_GREENMAIN(18), .T_YELLOWMAIN(3), .T_GREENSEC(6),
    .T_YELLOWSEC(2), .T_GREENPEATON(4), .T_REDPEATON(2), .TOL_CLK(TOL)
  ) dut (
    .clk(clk), .reset(reset), .main_lights(main_l), .sec_lights(sec_l),
    .pea_lights(pea_l), .sol_light(sol), .phase(phase), .fault(fault),
    .fault_code(fault_code), .fault_pulse(fault_pulse),
    .cycle_cnt(cycle_cnt), .ped_cnt(ped_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic int decode(input logic [7:0] pat);
    for (int i = 0; i < 6; i++) begin
      if (pat_tab[i] == pat) return i;
    end
    return 7;
  endfunction

  function automatic bit legal(input int a, input int b);
    for (int i = 0; i < 7; i++) begin
      if (leg_from[i] == a && leg_to[i] == b) return 1'b1;
    end
    return 1'b0;
  endfunction

  // ---------------- behavioural model ----------------
  int m_prev, m_run, m_pend;
  bit m_first, m_req, m_pend_mg, m_pend_pg;
  int e_phase, e_code, e_cyc, e_ped;
  bit e_fault, e_pulse;

  task automatic model_step();
    int p;
    int code;
    if (reset) begin
      m_prev = 0; m_run = 0; m_pend = 0; m_first = 1; m_req = 0;
      m_pend_mg = 0; m_pend_pg = 0;
      e_phase = 0; e_code = 0; e_cyc = 0; e_ped = 0; e_fault = 0; e_pulse = 0;
      return;
    end
    // Violations and entries seen on the previous clock become visible now.
    e_pulse = 0;
    if (m_pend != 0 && !e_fault) begin
      e_fault = 1; e_code = m_pend; e_pulse = 1;
    end
    if (m_pend_mg && e_cyc < 255) e_cyc++;
    if (m_pend_pg && e_ped < 255) e_ped++;
    m_pend = 0; m_pend_mg = 0; m_pend_pg = 0;

    p = decode({main_l, sec_l, pea_l});
    e_phase = p;
    if (p != m_prev) begin
      code = 0;
      if (p == 7) code = 1;
      else if (!legal(m_prev, p)) code = 2;
      else if (!m_first && m_run < exp_clks[m_prev] - TOL) code = 3;
      else if (m_prev == 4 && p == 5 && !m_req) code = 5;
      m_pend = code;
      m_pend_mg = (p == 1);
      m_pend_pg = (p == 5);
      if (p == 5) m_req = 0;
      else m_req = m_req | sol;
      m_first = 0;
      m_run = 1;
    end else begin
      m_run++;
      if (!m_first && p != 7 && m_run == exp_clks[p] + TOL + 1) m_pend = 4;
      m_req = m_req | sol;
    end
    m_prev = p;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (!reset && !tb_done) begin
      chk("phase", int'(phase), e_phase);
      chk("fault", int'(fault), int'(e_fault));
      chk("fault_code", int'(fault_code), e_code);
      chk("fault_pulse", int'(fault_pulse), int'(e_pulse));
      chk("cycle_cnt", int'(cycle_cnt), e_cyc);
      chk("ped_cnt", int'(ped_cnt), e_ped);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [7:0] pat, input int n, input logic s);
    {main_l, sec_l, pea_l} = pat;
    sol = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic hold(input int p, input int n);
    drive(pat_tab[p], n, 1'b0);
  endtask

  task automatic hold_rand(input logic [7:0] pat, input int n, input int prob);
    for (int i = 0; i < n; i++) begin
      drive(pat, 1, int'($urandom_range(0, 99)) < prob);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_phase"}, int'(phase), 0);
    chk({tag, "_fault"}, int'(fault), 0);
    chk({tag, "_code"}, int'(fault_code), 0);
    chk({tag, "_pulse"}, int'(fault_pulse), 0);
    chk({tag, "_cyc"}, int'(cycle_cnt), 0);
    chk({tag, "_ped"}, int'(ped_cnt), 0);
  endtask

  // Reset is raised between clock edges, so zero outputs prove it is async.
  task automatic do_reset(input bit check);
    @(negedge clk);
    reset = 1'b1;
    {main_l, sec_l, pea_l} = pat_tab[0];
    sol = 1'b0;
    #1;
    if (check) check_zero("async_rst");
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [7:0] illegal_pat();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    while (decode(v) != 7) v = 8'($urandom_range(0, 255));
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cur, nxt, dur, off, prob;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // 1: a full legal cycle.
    hold(0, 24);
    hold(1, 1);
    chk("t1_phase_lag", int'(phase), 1);
    hold(1, 143); hold(2, 24); hold(3, 48); hold(4, 16); hold(1, 3);
    chk("t1_fault", int'(fault), 0);
    chk("t1_cycle_cnt", int'(cycle_cnt), 2);

    // 2: a one-clock illegal combination during MG.
    hold(1, 50);
    drive(8'b001_001_10, 1, 1'b0);
    chk("t2_fault_early", int'(fault), 0);
    hold(1, 1);
    chk("t2_fault", int'(fault), 1);
    chk("t2_code", int'(fault_code), 1);
    chk("t2_pulse", int'(fault_pulse), 1);
    hold(1, 1);
    chk("t2_pulse_end", int'(fault_pulse), 0);

    // 3: MG jumps directly to SG.
    do_reset(1);
    hold(0, 24); hold(1, 144); hold(3, 2);
    chk("t3_code", int'(fault_code), 2);
    hold(3, 46); hold(2, 24); hold(3, 2);
    chk("t3_code_kept", int'(fault_code), 2);

    // 4: MG is too short.
    do_reset(0);
    hold(0, 24); hold(1, 100); hold(2, 1);
    chk("t4_fault_early", int'(fault), 0);
    hold(2, 1);
    chk("t4_code", int'(fault_code), 3);
    chk("t4_pulse", int'(fault_pulse), 1);

    // 5: a pedestrian phase without a request, then with one.
    do_reset(0);
    hold(0, 24); hold(1, 144); hold(2, 24); hold(3, 48); hold(4, 16); hold(5, 2);
    chk("t5_code_unreq", int'(fault_code), 5);
    do_reset(0);
    hold(0, 24); hold(1, 144); hold(2, 24); hold(3, 20);
    drive(pat_tab[3], 1, 1'b1);
    hold(3, 27); hold(4, 16); hold(5, 2);
    chk("t5_fault_req", int'(fault), 0);
    chk("t5_ped_cnt", int'(ped_cnt), 1);
    hold(5, 30); hold(0, 16); hold(1, 144); hold(2, 24); hold(3, 48); hold(4, 16); hold(5, 2);
    chk("t5_req_cleared", int'(fault_code), 5);
    chk("t5_ped_cnt2", int'(ped_cnt), 2);

    // 6: reset while faulted, then MG held too long.
    do_reset(1);
    hold(0, 24); hold(1, 146);
    chk("t6_fault_146", int'(fault), 0);
    hold(1, 1);
    chk("t6_fault_147", int'(fault), 0);
    hold(1, 1);
    chk("t6_fault", int'(fault), 1);
    chk("t6_code", int'(fault_code), 4);
    chk("t6_pulse", int'(fault_pulse), 1);
    hold(1, 52);
    chk("t6_pulse_end", int'(fault_pulse), 0);

    // Counter saturation: fast toggling keeps counting after the fault.
    do_reset(0);
    hold(0, 3);
    for (int i = 0; i < 260; i++) begin
      hold(1, 1); hold(2, 1);
    end
    hold(2, 3);
    chk("sat_cycle_cnt", int'(cycle_cnt), 255);
    chk("sat_code", int'(fault_code), 3);
    for (int i = 0; i < 260; i++) begin
      hold(5, 1); hold(0, 1);
    end
    hold(0, 3);
    chk("sat_ped_cnt", int'(ped_cnt), 255);

    // Randomized phase sequences.
    for (int r = 0; r < 40; r++) begin
      do_reset(0);
      prob = int'($urandom_range(0, 3));
      cur = 0;
      hold_rand(pat_tab[0], int'($urandom_range(3, 30)), prob);
      for (int k = 0; k < 8; k++) begin
        case (cur)
          0: nxt = 1;
          1: nxt = 2;
          2: nxt = 3;
          3: nxt = 4;
          4: nxt = ($urandom_range(0, 1) == 1) ? 5 : 1;
          default: nxt = 0;
        endcase
        case ($urandom_range(0, 19))
          0: hold_rand(illegal_pat(), int'($urandom_range(1, 3)), prob);
          1: nxt = int'($urandom_range(0, 5));
          default: ;
        endcase
        if ($urandom_range(0, 9) == 0) off = int'($urandom_range(0, 12)) - 6;
        else off = int'($urandom_range(0, 4)) - 2;
        dur = exp_clks[nxt] + off;
        hold_rand(pat_tab[nxt], dur, prob);
        cur = nxt;
      end
      hold(cur, 3);
    end

    tb_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
